// File: rtl/nfu_2b_accum.sv
// NFU-2B: registered binary adder tree over Tn product lanes, followed by a
// tagged multi-beat accumulator that emits full-width and saturated sums.
module nfu_2b_accum #(
  parameter int BIT_WIDTH = 16,
  parameter int Tn        = 16,
  parameter int LOG2_TN   = 4,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic                    i_first,
  input  logic                    i_last,
  input  logic [Tn*BIT_WIDTH-1:0] i_nfu2A,
  output logic                    o_valid,
  output logic [ACC_WIDTH-1:0]    o_sum_full,
  output logic [BIT_WIDTH-1:0]    o_sum,
  output logic                    o_overflow,
  output logic [CNT_WIDTH-1:0]    o_count,
  output logic                    o_protocol_err
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, sum_add, t_sum;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic                         ovf_q, ovf_d, err_d, start, add_ovf;
  logic [BIT_WIDTH-1:0]         sat_d;
  logic [LOG2_TN-1:0]           vld_sr, first_sr, last_sr;
  logic                         t_vld, t_first, t_last;

  // Stage 0 is the sign-extended input; stage s holds Tn>>s registered sums.
  for (genvar s = 0; s <= LOG2_TN; s++) begin : g_stage
    logic signed [ACC_WIDTH-1:0] node [Tn>>s];
    if (s == 0) begin : g_in
      always_comb begin
        for (int k = 0; k < Tn; k++)
          node[k] = ACC_WIDTH'($signed(i_nfu2A[k*BIT_WIDTH +: BIT_WIDTH]));
      end
    end else begin : g_add
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < (Tn>>s); j++) node[j] <= '0;
        end else begin
          for (int j = 0; j < (Tn>>s); j++)
            node[j] <= g_stage[s-1].node[2*j] + g_stage[s-1].node[2*j+1];
        end
      end
    end
  end

  assign t_sum   = g_stage[LOG2_TN].node[0];
  assign t_vld   = vld_sr[LOG2_TN-1];
  assign t_first = first_sr[LOG2_TN-1];
  assign t_last  = last_sr[LOG2_TN-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr   <= '0;
      first_sr <= '0;
      last_sr  <= '0;
    end else begin
      vld_sr[0]   <= i_valid;
      first_sr[0] <= i_first;
      last_sr[0]  <= i_last;
      for (int k = 1; k < LOG2_TN; k++) begin
        vld_sr[k]   <= vld_sr[k-1];
        first_sr[k] <= first_sr[k-1];
        last_sr[k]  <= last_sr[k-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = o_protocol_err;
    start   = 1'b0;
    sum_add = acc_q + t_sum;
    add_ovf = (acc_q[ACC_WIDTH-1] == t_sum[ACC_WIDTH-1]) &&
              (sum_add[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    if (t_vld) begin
      case (state_q)
        IDLE: begin
          start = 1'b1;
          if (!t_first) err_d = 1'b1;
        end
        ACCUM: begin
          start = t_first;
          if (t_first) err_d = 1'b1;
        end
        default: start = 1'b1;
      endcase
      if (start) begin
        acc_d = t_sum;
        cnt_d = CNT_WIDTH'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = sum_add;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        ovf_d = ovf_q | add_ovf;
      end
      state_d = t_last ? IDLE : ACCUM;
    end
  end

  // Clamp is taken from the wrapped accumulator value.
  always_comb begin
    if (acc_d > SAT_MAX)      sat_d = SAT_MAX[BIT_WIDTH-1:0];
    else if (acc_d < SAT_MIN) sat_d = SAT_MIN[BIT_WIDTH-1:0];
    else                      sat_d = acc_d[BIT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      o_protocol_err <= 1'b0;
      o_valid        <= 1'b0;
      o_sum_full     <= '0;
      o_sum          <= '0;
      o_overflow     <= 1'b0;
      o_count        <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      o_protocol_err <= err_d;
      o_valid        <= t_vld & t_last;
      if (t_vld && t_last) begin
        o_sum_full <= acc_d;
        o_sum      <= sat_d;
        o_overflow <= ovf_d;
        o_count    <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_nfu_2b_accum.sv
// Scoreboard bench for nfu_2b_accum: two instances (32-bit and 20-bit
// accumulator) share stimulus; an arithmetic model predicts each result.
module tb_nfu_2b_accum;
  localparam int BW = 16, TN = 16, LG = 4, CW = 8;

  typedef struct {
    longint sf;
    longint s;
    bit     ov;
    longint cnt;
    bit     err;
    longint cyc;
  } exp_t;

  logic clk = 0, rst = 1;
  logic i_valid = 0, i_first = 0, i_last = 0;
  logic [TN*BW-1:0] i_data = '0;

  logic v0, ov0, e0, v1, ov1, e1;
  logic [31:0] sf0;
  logic [19:0] sf1;
  logic [15:0] s0, s1;
  logic [7:0] c0, c1;

  nfu_2b_accum #(.BIT_WIDTH(BW), .Tn(TN), .LOG2_TN(LG), .ACC_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
    .i_nfu2A(i_data), .o_valid(v0), .o_sum_full(sf0), .o_sum(s0),
    .o_overflow(ov0), .o_count(c0), .o_protocol_err(e0));

  nfu_2b_accum #(.BIT_WIDTH(BW), .Tn(TN), .LOG2_TN(LG), .ACC_WIDTH(20), .CNT_WIDTH(CW)) dut20 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
    .i_nfu2A(i_data), .o_valid(v1), .o_sum_full(sf1), .o_sum(s1),
    .o_overflow(ov1), .o_count(c1), .o_protocol_err(e1));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  exp_t q[2][$];
  exp_t last_e[2];
  bit in_n[2], ovf[2], err[2];
  longint acc[2], cnt[2];

  function automatic int aw(int i);
    return (i == 0) ? 32 : 20;
  endfunction

  function automatic longint wrap(longint x, int a);
    longint m, r;
    m = longint'(1) <<< a;
    r = x % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic longint sat(longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic void chk(string nm, int inst, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s inst%0d at cycle %0d: got %0d, expected %0d", nm, inst, cyc, act, expv);
    end
  endfunction

  function automatic logic [TN*BW-1:0] fill(input logic [15:0] v);
    logic [TN*BW-1:0] d;
    for (int k = 0; k < TN; k++) d[k*BW +: BW] = v;
    return d;
  endfunction

  function automatic logic [TN*BW-1:0] rnd_lanes();
    logic [TN*BW-1:0] d;
    for (int k = 0; k < TN; k++) d[k*BW +: BW] = 16'($urandom);
    return d;
  endfunction

  // Neuron semantics expressed directly as arithmetic on the beat total.
  function automatic void model_beat(bit f, bit l, longint t);
    longint s, lo, hi;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      hi = (longint'(1) <<< (aw(i) - 1)) - 1;
      lo = -hi - 1;
      if (!in_n[i] && !f) err[i] = 1;
      if (in_n[i] && f) err[i] = 1;
      if (!in_n[i] || f) begin
        acc[i] = wrap(t, aw(i));
        cnt[i] = 1;
        ovf[i] = 0;
      end else begin
        s = acc[i] + t;
        if (s > hi || s < lo) ovf[i] = 1;
        acc[i] = wrap(s, aw(i));
        cnt[i] = (cnt[i] < 255) ? cnt[i] + 1 : 255;
      end
      if (l) begin
        e.sf = acc[i]; e.s = sat(acc[i]); e.ov = ovf[i]; e.cnt = cnt[i];
        e.err = err[i]; e.cyc = cyc + LG + 1;
        q[i].push_back(e);
        in_n[i] = 0;
      end else begin
        in_n[i] = 1;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit f, bit l, logic [TN*BW-1:0] d);
    longint t;
    logic signed [BW-1:0] ln;
    t = 0;
    for (int k = 0; k < TN; k++) begin
      ln = d[k*BW +: BW];
      t += ln;
    end
    i_valid = 1; i_first = f; i_last = l; i_data = d;
    model_beat(f, l, t);
    step();
  endtask

  task automatic idle(int n);
    i_valid = 0; i_first = 0; i_last = 0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1;
    i_valid = 0; i_first = 0; i_last = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      in_n[i] = 0; ovf[i] = 0; err[i] = 0; acc[i] = 0; cnt[i] = 0;
      last_e[i] = '{0, 0, 0, 0, 0, 0};
    end
    chk("rst_valid", 0, v0, 0);
    chk("rst_sum_full", 0, sf0, 0);
    chk("rst_sum", 0, s0, 0);
    chk("rst_count", 0, c0, 0);
    chk("rst_overflow", 0, ov0, 0);
    chk("rst_err", 0, e0, 0);
    chk("rst_valid", 1, v1, 0);
    chk("rst_sum_full", 1, sf1, 0);
    step(); step();
    rst = 0;
  endtask

  always @(negedge clk) begin : mon
    logic vv, ovv, erv;
    longint sfv, sv, cv;
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0) begin
          vv = v0; sfv = $signed(sf0); sv = $signed(s0); ovv = ov0; cv = c0; erv = e0;
        end else begin
          vv = v1; sfv = $signed(sf1); sv = $signed(s1); ovv = ov1; cv = c1; erv = e1;
        end
        if (vv) begin
          if (q[i].size() == 0) begin
            chk("unexpected_valid", i, 1, 0);
          end else begin
            e = q[i].pop_front();
            chk("latency", i, cyc, e.cyc);
            chk("sum_full", i, sfv, e.sf);
            chk("sum_sat", i, sv, e.s);
            chk("overflow", i, ovv, e.ov);
            chk("count", i, cv, e.cnt);
            chk("protocol_err", i, erv, e.err);
            last_e[i] = e;
          end
        end else begin
          chk("hold_sum_full", i, sfv, last_e[i].sf);
          chk("hold_count", i, cv, last_e[i].cnt);
        end
      end
    end
  end

  initial begin
    int budget;
    bit f, l;
    do_reset();

    issue(1, 1, fill(16'h0001)); idle(8);

    issue(1, 0, fill(16'd100)); idle(2);
    issue(0, 0, fill(16'd100)); issue(0, 1, fill(16'd100)); idle(8);

    issue(1, 1, fill(16'hF800)); idle(2);
    issue(1, 0, fill(16'h7FFF)); issue(0, 1, fill(16'h7FFF)); idle(8);

    for (int v = 1; v <= 8; v++) issue(1, 1, fill(16'(v)));
    idle(8);

    issue(0, 1, fill(16'd3)); idle(8);
    issue(1, 0, fill(16'd5)); issue(1, 0, fill(16'd7)); issue(0, 1, fill(16'd2)); idle(8);

    issue(1, 0, fill(16'd9)); issue(0, 1, fill(16'd9)); idle(1);
    do_reset();
    idle(8);
    issue(1, 1, fill(16'd2)); idle(8);

    issue(1, 0, fill(16'h7FFF)); issue(0, 0, fill(16'h7FFF)); issue(0, 1, fill(16'h7FFF));
    idle(8);

    issue(1, 0, rnd_lanes());
    for (int k = 0; k < 298; k++) issue(0, 0, rnd_lanes());
    issue(0, 1, rnd_lanes()); idle(8);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3) == 0) begin
        idle(1);
      end else begin
        f = in_n[0] ? ($urandom_range(15) == 0) : ($urandom_range(7) != 0);
        l = ($urandom_range(3) == 0);
        issue(f, l, rnd_lanes());
      end
    end
    if (in_n[0]) issue(0, 1, rnd_lanes());

    budget = 0;
    idle(1);
    while ((q[0].size() != 0 || q[1].size() != 0) && budget < 50) begin
      idle(1);
      budget++;
    end
    for (int i = 0; i < 2; i++)
      if (q[i].size() != 0) chk("pending_results", i, q[i].size(), 0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
